// File: rtl/demux_tdm_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
package demux_tdm_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage : demux_tdm_pkg

// File: rtl/tdm_slot_counter.sv
// Wrapping 2-bit slot counter. Priority order: clear, then load-to-1, then advance.
module tdm_slot_counter
  import demux_tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  load1,
  input  logic  advance,
  output slot_t slot
);

  slot_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clear) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = slot_t'(1);
    end else if (advance) begin
      slot_d = slot_q + slot_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule : tdm_slot_counter

// File: rtl/demux1_4_tdm.sv
// 1:4 TDM demultiplexer: aligns to frame_sync on slot 0 and emits all four channels per frame.
// Define TDM_LOSS_DETECT_EN to drop lock on a missing slot-0 sync; otherwise flywheel mode.
module demux1_4_tdm
  import demux_tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [1:0]       slot
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] stage_q [NUM_CH-1];
  logic [WIDTH-1:0] stage_d [NUM_CH-1];
  logic [WIDTH-1:0] y_q     [NUM_CH];
  logic [WIDTH-1:0] y_d     [NUM_CH];
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;
  logic             cnt_clear, cnt_load1, cnt_advance;
  slot_t            slot_cur;

  tdm_slot_counter u_slot_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .load1   (cnt_load1),
    .advance (cnt_advance),
    .slot    (slot_cur)
  );

  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    y_d           = y_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    cnt_clear     = 1'b0;
    cnt_load1     = 1'b0;
    cnt_advance   = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (din_valid && frame_sync) begin
          stage_d[0] = din;
          cnt_load1  = 1'b1;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          if (frame_sync && (slot_cur != '0)) begin
            // Early sync: restart the frame at this sample, partial frame is abandoned
            sync_err_d = 1'b1;
            stage_d[0] = din;
            cnt_load1  = 1'b1;
`ifdef TDM_LOSS_DETECT_EN
          end else if (!frame_sync && (slot_cur == '0)) begin
            sync_err_d = 1'b1;
            cnt_clear  = 1'b1;
            state_d    = HUNT;
`endif
          end else begin
            cnt_advance = 1'b1;
            unique case (slot_cur)
              2'd0: stage_d[0] = din;
              2'd1: stage_d[1] = din;
              2'd2: stage_d[2] = din;
              2'd3: begin
                y_d[0]        = stage_q[0];
                y_d[1]        = stage_q[1];
                y_d[2]        = stage_q[2];
                y_d[3]        = din;
                frame_valid_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      stage_q       <= '{default: '0};
      y_q           <= '{default: '0};
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign y0          = y_q[0];
  assign y1          = y_q[1];
  assign y2          = y_q[2];
  assign y3          = y_q[3];
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCKED);
  assign slot        = slot_cur;

endmodule : demux1_4_tdm

// File: tb/tb_demux1_4_tdm.sv
// Directed self-checking bench for demux1_4_tdm (WIDTH=4).
module tb_demux1_4_tdm;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] y0, y1, y2, y3;
  logic         frame_valid, locked, sync_err;
  logic [1:0]   slot;

  int tests = 0;
  int fails = 0;

  demux1_4_tdm #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .slot        (slot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d);
    check({tag, ".fv"}, 8'(frame_valid), 8'd1);
    check({tag, ".y0"}, 8'(y0), 8'(a));
    check({tag, ".y1"}, 8'(y1), 8'(b));
    check({tag, ".y2"}, 8'(y2), 8'(c));
    check({tag, ".y3"}, 8'(y3), 8'(d));
    check({tag, ".serr"}, 8'(sync_err), 8'd0);
  endtask

  task automatic send(input logic [W-1:0] d, input logic fs);
    @(negedge clk);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid  = 1'b0;
      frame_sync = 1'b1;
      din        = 4'hF;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst.y0", 8'(y0), 8'd0);
    check("rst.y3", 8'(y3), 8'd0);
    check("rst.fv", 8'(frame_valid), 8'd0);
    check("rst.locked", 8'(locked), 8'd0);
    check("rst.serr", 8'(sync_err), 8'd0);
    check("rst.slot", 8'(slot), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame 1,2,3,4
    send(4'd1, 1'b1);
    check("t1.locked", 8'(locked), 8'd1);
    check("t1.slot", 8'(slot), 8'd1);
    check("t1.fv0", 8'(frame_valid), 8'd0);
    send(4'd2, 1'b0);
    send(4'd3, 1'b0);
    check("t1.slot3", 8'(slot), 8'd3);
    send(4'd4, 1'b0);
    check_frame("t1", 4'd1, 4'd2, 4'd3, 4'd4);
    check("t1.slotwrap", 8'(slot), 8'd0);
    idle(1);
    check("t1.fvpulse", 8'(frame_valid), 8'd0);
    check("t1.hold", 8'(y2), 8'd3);
    check("t1.lockhold", 8'(locked), 8'd1);

    // Leading samples before sync are ignored
    do_reset();
    send(4'd9, 1'b0);
    send(4'd9, 1'b0);
    check("t2.hunt", 8'(locked), 8'd0);
    check("t2.slot", 8'(slot), 8'd0);
    send(4'd5, 1'b1);
    send(4'd6, 1'b0);
    send(4'd7, 1'b0);
    send(4'd8, 1'b0);
    check_frame("t2", 4'd5, 4'd6, 4'd7, 4'd8);

    // Early sync at slot 2
    send(4'd10, 1'b1);
    send(4'd11, 1'b0);
    send(4'd12, 1'b1);
    check("t3.serr", 8'(sync_err), 8'd1);
    check("t3.fv", 8'(frame_valid), 8'd0);
    check("t3.slot", 8'(slot), 8'd1);
    check("t3.locked", 8'(locked), 8'd1);
    check("t3.hold", 8'(y0), 8'd5);
    send(4'd13, 1'b0);
    check("t3.serrpulse", 8'(sync_err), 8'd0);
    send(4'd14, 1'b0);
    send(4'd15, 1'b0);
    check_frame("t3", 4'd12, 4'd13, 4'd14, 4'd15);

    // Gaps between slots
    send(4'd1, 1'b1);
    idle(1);
    check("t4.gapslot", 8'(slot), 8'd1);
    send(4'd2, 1'b0);
    idle(2);
    send(4'd3, 1'b0);
    idle(3);
    check("t4.gapfv", 8'(frame_valid), 8'd0);
    check("t4.gapslot3", 8'(slot), 8'd3);
    send(4'd4, 1'b0);
    check_frame("t4", 4'd1, 4'd2, 4'd3, 4'd4);

    // Missing sync at slot 0
    send(4'd6, 1'b0);
`ifdef TDM_LOSS_DETECT_EN
    check("t5.serr", 8'(sync_err), 8'd1);
    check("t5.locked", 8'(locked), 8'd0);
    check("t5.slot", 8'(slot), 8'd0);
    send(4'd7, 1'b0);
    check("t5.hunt", 8'(locked), 8'd0);
    check("t5.hold", 8'(y0), 8'd1);
`else
    check("t5.serr", 8'(sync_err), 8'd0);
    check("t5.locked", 8'(locked), 8'd1);
    check("t5.slot", 8'(slot), 8'd1);
    send(4'd7, 1'b0);
    send(4'd8, 1'b0);
    send(4'd9, 1'b0);
    check_frame("t5", 4'd6, 4'd7, 4'd8, 4'd9);
`endif

    // Reset mid-frame
    send(4'd1, 1'b1);
    send(4'd2, 1'b0);
    check("t6.pre", 8'(slot), 8'd2);
    rst_n = 1'b0;
    #1;
    check("t6.y0", 8'(y0), 8'd0);
    check("t6.y3", 8'(y3), 8'd0);
    check("t6.locked", 8'(locked), 8'd0);
    check("t6.slot", 8'(slot), 8'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    din_valid = 1'b0;
    send(4'd5, 1'b1);
    send(4'd6, 1'b0);
    send(4'd7, 1'b0);
    send(4'd8, 1'b0);
    check_frame("t6", 4'd5, 4'd6, 4'd7, 4'd8);

    idle(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_demux1_4_tdm
